// File: rtl/adaptive_threshold_sequencer_pkg.sv
// Shared types and defaults for the adaptive threshold sequencer.
// ADAPTIVE_SEQ_WATCHDOG_EN adds the ERROR state to the encoding.
package adaptive_threshold_pkg;

    localparam int DATA_BITS           = 8;
    localparam int DEFAULT_WIDTH_BITS  = 8;
    localparam int DEFAULT_HEIGHT_BITS = 8;

`ifdef ADAPTIVE_SEQ_WATCHDOG_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BOX_RUN = 3'd1,
        THR_RUN = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } seqState_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOX_RUN = 2'd1,
        THR_RUN = 2'd2,
        DONE    = 2'd3
    } seqState_t;
`endif

endpackage

// File: rtl/adaptive_threshold_sequencer_if.sv
// Host read port of the sequencer; signal names are from the sequencer's side.
interface adaptive_threshold_sequencer_if #(
    parameter int WIDTH_BITS  = adaptive_threshold_pkg::DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS = adaptive_threshold_pkg::DEFAULT_HEIGHT_BITS
);
    import adaptive_threshold_pkg::*;

    logic                   iHostRdReq;
    logic [WIDTH_BITS-1:0]  iHostRdcol;
    logic [HEIGHT_BITS-1:0] iHostRdrow;
    logic                   oHostRdGrant;
    logic                   oHostRdValid;
    logic [DATA_BITS-1:0]   oHostRdData;

    modport master (
        output iHostRdReq, iHostRdcol, iHostRdrow,
        input  oHostRdGrant, oHostRdValid, oHostRdData
    );

    modport slave (
        input  iHostRdReq, iHostRdcol, iHostRdrow,
        output oHostRdGrant, oHostRdValid, oHostRdData
    );

endinterface

// File: rtl/adaptive_threshold_sequencer_middle_ram_read_arbiter.sv
// Middle-RAM read port mux: threshold stage owns the port during THR_RUN,
// otherwise the host is granted combinationally and gets data one cycle later.
module middle_ram_read_arbiter
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEFAULT_HEIGHT_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   thrPhase,
    input  logic [WIDTH_BITS-1:0]  thrCol,
    input  logic [HEIGHT_BITS-1:0] thrRow,
    input  logic                   hostReq,
    input  logic [WIDTH_BITS-1:0]  hostCol,
    input  logic [HEIGHT_BITS-1:0] hostRow,
    output logic                   hostGrant,
    output logic                   hostValid,
    output logic [DATA_BITS-1:0]   hostData,
    output logic [WIDTH_BITS-1:0]  ramCol,
    output logic [HEIGHT_BITS-1:0] ramRow,
    input  logic [DATA_BITS-1:0]   ramData
);

    logic validQ;

    assign hostGrant = hostReq && !thrPhase;
    assign ramCol    = thrPhase ? thrCol : hostCol;
    assign ramRow    = thrPhase ? thrRow : hostRow;

    // Valid tracks the grant regardless of the next phase, so a grant on the
    // last pre-threshold cycle still returns its data.
    always_ff @(posedge clock) begin
        if (reset) begin
            validQ <= 1'b0;
        end else begin
            validQ <= hostGrant;
        end
    end

    assign hostValid = validQ;
    assign hostData  = validQ ? ramData : '0;

endmodule

// File: rtl/adaptive_threshold_sequencer.sv
// Sequences box filter then threshold stage and arbitrates the middle-RAM read port.
// Optional per-phase watchdog with ERROR state: define ADAPTIVE_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | waiting for iStart, box filter held in reset
// BOX_RUN | box filter running, waiting for iBoxFinished
// THR_RUN | threshold stage owns the RAM port, waiting for iThrFinished
// DONE    | pass complete, iStart begins a new pass
// ERROR   | phase watchdog expired (watchdog build only), iStart retries
module adaptive_threshold_sequencer
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS     = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS    = DEFAULT_HEIGHT_BITS,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oBoxNotReset,
    input  logic                   iBoxFinished,
    output logic                   oThrStart,
    input  logic                   iThrFinished,
    input  logic [WIDTH_BITS-1:0]  iThrRdcol,
    input  logic [HEIGHT_BITS-1:0] iThrRdrow,
    adaptive_threshold_sequencer_if.slave hostRd,
    output logic [WIDTH_BITS-1:0]  oRamRdcol,
    output logic [HEIGHT_BITS-1:0] oRamRdrow,
    input  logic [DATA_BITS-1:0]   iRamRddata
);

    seqState_t state;
    seqState_t stateNext;
    logic      firstCycle;
    logic      boxNotResetQ;
    logic      phaseTimeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            firstCycle   <= 1'b0;
            boxNotResetQ <= 1'b0;
        end else begin
            state        <= stateNext;
            firstCycle   <= (stateNext != state);
            boxNotResetQ <= (stateNext == BOX_RUN);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (iStart) stateNext = BOX_RUN;
            end
            BOX_RUN: begin
                // The finished flag may be stale from the previous pass on entry.
                if (iBoxFinished && !firstCycle) stateNext = THR_RUN;
`ifdef ADAPTIVE_SEQ_WATCHDOG_EN
                else if (phaseTimeout) stateNext = ERROR;
`endif
            end
            THR_RUN: begin
                if (iThrFinished) stateNext = DONE;
`ifdef ADAPTIVE_SEQ_WATCHDOG_EN
                else if (phaseTimeout) stateNext = ERROR;
`endif
            end
`ifdef ADAPTIVE_SEQ_WATCHDOG_EN
            ERROR: begin
                if (iStart) stateNext = BOX_RUN;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    assign oBusy        = (state == BOX_RUN) || (state == THR_RUN);
    assign oDone        = (state == DONE);
    assign oThrStart    = (state == THR_RUN) && firstCycle;
    assign oBoxNotReset = boxNotResetQ;

`ifdef ADAPTIVE_SEQ_WATCHDOG_EN
    localparam int COUNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [COUNT_BITS-1:0] phaseCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            phaseCount <= '0;
        end else if (stateNext != state) begin
            phaseCount <= '0;
        end else if (oBusy) begin
            phaseCount <= phaseCount + 1'b1;
        end
    end

    assign phaseTimeout = oBusy && (phaseCount == LAST_COUNT);
`else
    assign phaseTimeout = 1'b0;
`endif

    middle_ram_read_arbiter #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS)
    ) uArbiter (
        .clock     (clock),
        .reset     (reset),
        .thrPhase  (state == THR_RUN),
        .thrCol    (iThrRdcol),
        .thrRow    (iThrRdrow),
        .hostReq   (hostRd.iHostRdReq),
        .hostCol   (hostRd.iHostRdcol),
        .hostRow   (hostRd.iHostRdrow),
        .hostGrant (hostRd.oHostRdGrant),
        .hostValid (hostRd.oHostRdValid),
        .hostData  (hostRd.oHostRdData),
        .ramCol    (oRamRdcol),
        .ramRow    (oRamRdrow),
        .ramData   (iRamRddata)
    );

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// Bench for adaptive_threshold_sequencer: directed phase sequencing plus a
// host-read scoreboard; watchdog section needs ADAPTIVE_SEQ_WATCHDOG_EN.
module tb_adaptive_threshold_sequencer;

    logic       clock;
    logic       reset;
    logic       iStart;
    logic       oBusy;
    logic       oDone;
    logic       oBoxNotReset;
    logic       iBoxFinished;
    logic       oThrStart;
    logic       iThrFinished;
    logic [7:0] iThrRdcol;
    logic [7:0] iThrRdrow;
    logic [7:0] oRamRdcol;
    logic [7:0] oRamRdrow;
    logic [7:0] iRamRddata;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    adaptive_threshold_sequencer_if #(.WIDTH_BITS(8), .HEIGHT_BITS(8)) hostBus ();

    adaptive_threshold_sequencer #(
        .WIDTH_BITS     (8),
        .HEIGHT_BITS    (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iStart       (iStart),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oBoxNotReset (oBoxNotReset),
        .iBoxFinished (iBoxFinished),
        .oThrStart    (oThrStart),
        .iThrFinished (iThrFinished),
        .iThrRdcol    (iThrRdcol),
        .iThrRdrow    (iThrRdrow),
        .hostRd       (hostBus.slave),
        .oRamRdcol    (oRamRdcol),
        .oRamRdrow    (oRamRdrow),
        .iRamRddata   (iRamRddata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] ramModel(input logic [7:0] col, input logic [7:0] row);
        if (col == 8'd3 && row == 8'd5) return 8'h12;
        if (col == 8'd4 && row == 8'd5) return 8'h34;
        return {col[3:0], row[3:0]};
    endfunction

    // Registered RAM: data for the address presented appears one cycle later.
    always @(posedge clock) iRamRddata <= ramModel(oRamRdcol, oRamRdrow);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hostReq(input logic req, input logic [7:0] col, input logic [7:0] row);
        hostBus.iHostRdReq = req;
        hostBus.iHostRdcol = col;
        hostBus.iHostRdrow = row;
        #1;
    endtask

    always @(negedge clock) begin
        if (hostBus.oHostRdValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hostRdUnexpected actual=%0h required=none", hostBus.oHostRdData);
            end else begin
                check("hostRdData", hostBus.oHostRdData, expQ.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL globalTimeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int boxHigh;
        int thrStarts;
        int grants;
        int addrBad;

        reset        = 1'b1;
        iStart       = 1'b0;
        iBoxFinished = 1'b0;
        iThrFinished = 1'b0;
        iThrRdcol    = 8'h00;
        iThrRdrow    = 8'h00;
        hostBus.iHostRdReq = 1'b0;
        hostBus.iHostRdcol = 8'h00;
        hostBus.iHostRdrow = 8'h00;
        repeat (3) tick();

        check("rstBusy", oBusy, 0);
        check("rstDone", oDone, 0);
        check("rstBoxNotReset", oBoxNotReset, 0);
        check("rstThrStart", oThrStart, 0);
        check("rstHostValid", hostBus.oHostRdValid, 0);
        check("rstHostData", hostBus.oHostRdData, 0);
        reset = 1'b0;
        tick();

        // Box phase: 50 cycles, one host read mid-phase, one on the last cycle.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("boxEntryBusy", oBusy, 1);
        boxHigh = 0;
        for (int i = 0; i < 50; i++) begin
            if (oBoxNotReset) boxHigh++;
            iStart       = (i == 10);
            iThrFinished = (i == 5);
            if (i == 20) begin
                hostReq(1'b1, 8'd7, 8'd9);
                check("grantInBox", hostBus.oHostRdGrant, 1);
                expQ.push_back(ramModel(8'd7, 8'd9));
            end else if (i == 49) begin
                hostReq(1'b1, 8'd6, 8'd1);
                check("grantLastBox", hostBus.oHostRdGrant, 1);
                expQ.push_back(ramModel(8'd6, 8'd1));
                iBoxFinished = 1'b1;
            end else begin
                hostReq(1'b0, 8'd0, 8'd0);
            end
            tick();
        end
        iBoxFinished = 1'b0;
        iStart       = 1'b0;
        iThrFinished = 1'b0;
        check("boxCycles", boxHigh, 50);
        check("thrBoxNotReset", oBoxNotReset, 0);
        check("thrBusy", oBusy, 1);

        // Threshold phase: host keeps requesting (6,1) throughout.
        thrStarts = 0;
        grants    = 0;
        addrBad   = 0;
        for (int j = 0; j < 30; j++) begin
            iThrRdcol = 8'(j + 32);
            iThrRdrow = 8'(j + 64);
            #1;
            if (oThrStart) thrStarts++;
            if (hostBus.oHostRdGrant) grants++;
            if (oRamRdcol !== iThrRdcol || oRamRdrow !== iThrRdrow) addrBad++;
            iThrFinished = (j == 29);
            tick();
        end
        iThrFinished = 1'b0;
        check("thrStartPulses", thrStarts, 1);
        check("thrGrants", grants, 0);
        check("thrAddrBad", addrBad, 0);
        check("doneDone", oDone, 1);
        check("doneBusy", oBusy, 0);
        check("doneGrantResume", hostBus.oHostRdGrant, 1);
        check("doneRamCol", oRamRdcol, 8'd6);
        expQ.push_back(ramModel(8'd6, 8'd1));
        tick();

        // Back-to-back host reads in DONE.
        hostReq(1'b1, 8'd3, 8'd5);
        expQ.push_back(8'h12);
        tick();
        check("b2bValid1", hostBus.oHostRdValid, 1);
        check("b2bData1", hostBus.oHostRdData, 8'h12);
        hostReq(1'b1, 8'd4, 8'd5);
        expQ.push_back(8'h34);
        tick();
        check("b2bValid2", hostBus.oHostRdValid, 1);
        check("b2bData2", hostBus.oHostRdData, 8'h34);
        hostReq(1'b0, 8'd0, 8'd0);
        tick();
        check("b2bValidEnd", hostBus.oHostRdValid, 0);

        repeat (5) tick();
        check("noRestartDone", oDone, 1);
        check("noRestartBusy", oBusy, 0);

        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("restartDone", oDone, 0);
        check("restartBusy", oBusy, 1);
        check("restartBoxNotReset", oBoxNotReset, 1);

        // Reset mid-box with a granted host read that must be dropped.
        repeat (3) tick();
        reset = 1'b1;
        hostReq(1'b1, 8'd2, 8'd2);
        tick();
        check("midRstBusy", oBusy, 0);
        check("midRstDone", oDone, 0);
        check("midRstBoxNotReset", oBoxNotReset, 0);
        check("midRstThrStart", oThrStart, 0);
        check("midRstValid", hostBus.oHostRdValid, 0);
        check("midRstData", hostBus.oHostRdData, 0);
        reset = 1'b0;
        hostReq(1'b0, 8'd0, 8'd0);
        repeat (2) tick();
        check("postRstIdle", oBusy, 0);

        // A stale iBoxFinished is ignored in the first BOX_RUN cycle.
        iStart       = 1'b1;
        iBoxFinished = 1'b1;
        tick();
        iStart = 1'b0;
        check("boxFirstNotReset", oBoxNotReset, 1);
        tick();
        check("boxSecondThrStart", oThrStart, 0);
        check("boxSecondNotReset", oBoxNotReset, 1);
        tick();
        check("earlyThrStart", oThrStart, 1);
        iBoxFinished = 1'b0;
        iThrFinished = 1'b1;
        tick();
        iThrFinished = 1'b0;
        check("earlyDone", oDone, 1);

`ifdef ADAPTIVE_SEQ_WATCHDOG_EN
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (15) tick();
        check("wdogBeforeBusy", oBusy, 1);
        tick();
        check("wdogErrBusy", oBusy, 0);
        check("wdogErrDone", oDone, 0);
        check("wdogErrBoxNotReset", oBoxNotReset, 0);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("wdogRecoverBusy", oBusy, 1);
        check("wdogRecoverBoxNotReset", oBoxNotReset, 1);
`endif

        repeat (3) tick();
        check("scoreboardEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adaptive_threshold_sequencer.md
ADAPTIVE_THRESHOLD_SEQUENCER -- requirements
Module: adaptive_threshold_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH_BITS, default 8, giving the image column address width.
REQ-002 The block SHALL have parameter HEIGHT_BITS, default 8, giving the image row address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 262144, giving the per-phase watchdog limit (used only under REQ-030).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port iStart, input, 1 bit: single-cycle request to run a full pass.
REQ-007 The block SHALL have port oBusy, output, 1 bit: high while in BOX_RUN or THR_RUN.
REQ-008 The block SHALL have port oDone, output, 1 bit: high while in DONE.
REQ-009 The block SHALL have port oBoxNotReset, output, 1 bit: drives the box filter's active-low not_reset.
REQ-010 The block SHALL have port iBoxFinished, input, 1 bit: box filter finished flag.
REQ-011 The block SHALL have ports oThrStart (output, 1 bit: threshold-stage start pulse) and iThrFinished (input, 1 bit: threshold-stage done).
REQ-012 The block SHALL have ports iThrRdcol (input, WIDTH_BITS) and iThrRdrow (input, HEIGHT_BITS): threshold-stage middle-RAM read address.
REQ-013 The block SHALL have ports iHostRdReq (input, 1), iHostRdcol (input, WIDTH_BITS), iHostRdrow (input, HEIGHT_BITS), oHostRdGrant (output, 1), oHostRdValid (output, 1) and oHostRdData (output, 8): host read port.
REQ-014 The block SHALL have ports oRamRdcol (output, WIDTH_BITS), oRamRdrow (output, HEIGHT_BITS) and iRamRddata (input, 8): middle-RAM read port, 1-cycle registered latency.

Function
REQ-015 The FSM SHALL have states IDLE, BOX_RUN, THR_RUN and DONE, plus ERROR under REQ-030.
REQ-016 In IDLE or DONE with iStart=1, the FSM SHALL go to BOX_RUN on the next edge.
REQ-017 oBoxNotReset SHALL be registered and high only in BOX_RUN, so the box filter is held in reset in every other state.
REQ-018 iBoxFinished SHALL be honoured only in BOX_RUN, at least 1 cycle after entry; it causes a transition to THR_RUN.
REQ-019 oThrStart SHALL be exactly one cycle high, in the first cycle of THR_RUN.
REQ-020 In THR_RUN, iThrFinished=1 SHALL cause a transition to DONE; iThrFinished in other states SHALL be ignored.
REQ-021 iStart while oBusy=1 SHALL be ignored and not queued.
REQ-022 In THR_RUN, the RAM read address SHALL be the threshold address, with oHostRdGrant=0.
REQ-023 In IDLE, DONE and BOX_RUN, the RAM read address SHALL be the host address, with oHostRdGrant=iHostRdReq (combinational).
REQ-024 oHostRdValid SHALL be high exactly 1 cycle after a granted request, with oHostRdData=iRamRddata in that cycle.
REQ-025 A host request that is denied SHALL be held by the host; the block SHALL NOT buffer it.
REQ-026 Back-to-back granted host reads SHALL yield one valid result per cycle.
REQ-027 A grant in the last cycle before THR_RUN SHALL still complete its valid in the following cycle.

Reset
REQ-028 On reset=1 at any time, the next state SHALL be IDLE, with oBusy=0, oDone=0, oBoxNotReset=0, oThrStart=0, oHostRdValid=0, oHostRdData=0 and the watchdog=0.
REQ-029 Reset in mid-phase SHALL abort the pass; the box filter is held in reset via oBoxNotReset=0 from the next cycle.

Configuration
REQ-030 With ADAPTIVE_SEQ_WATCHDOG_EN defined, a phase counter SHALL clear on entry to BOX_RUN/THR_RUN and count each cycle; reaching TIMEOUT_CYCLES moves to ERROR, where oBusy=0, oDone=0 and oBoxNotReset=0, and iStart leaves ERROR to BOX_RUN.
REQ-031 Without ADAPTIVE_SEQ_WATCHDOG_EN, the counter and ERROR state SHALL be absent, and the phases SHALL wait indefinitely.

Structure
REQ-032 Package adaptive_threshold_pkg SHALL hold the state encoding, the default WIDTH_BITS/HEIGHT_BITS and the data width 8.
REQ-033 The read-port mux and valid pipeline SHALL be sub-module middle_ram_read_arbiter; the FSM stays in the top.

Verification
REQ-034 Pulse iStart in IDLE; stub iBoxFinished 50 cycles later -> oBoxNotReset high for exactly those BOX_RUN cycles, oThrStart one pulse, oBusy=1.
REQ-035 Assert iThrFinished 30 cycles into THR_RUN -> DONE next cycle, oDone=1, oBusy=0; then iStart -> BOX_RUN, oDone=0.
REQ-036 Host reads (3,5),(4,5) back-to-back in DONE with RAM model data 0x12,0x34 -> oHostRdValid on 2 consecutive cycles with 0x12, 0x34.
REQ-037 Host holds iHostRdReq through THR_RUN -> oHostRdGrant=0 and RAM address=threshold address throughout; grant resumes the cycle DONE is entered.
REQ-038 reset=1 mid-BOX_RUN, and iStart pulsed in BOX_RUN -> IDLE with all outputs 0 next cycle; iStart ignored with no restart after DONE.
REQ-039 With ADAPTIVE_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=16, withhold iBoxFinished -> ERROR after 16 cycles, oBoxNotReset=0; iStart recovers to BOX_RUN.
